pipe_fetch_unit: RTL and testbench
==================================

Name: pipe_fetch_unit

Overview:
- Instruction-fetch stage of the 3-stage pipelined processor, sitting directly upstream of the CCG1 pipeline latch.
- Owns the program counter and drives the instruction-memory request/acknowledge interface.
- Delivers the 16-bit instruction segment (opcode[15:8], operand[7:0]) and the next-PC value to CCG1.
- Applies PC redirects from the control stage (jump, call, return), squashes wrong-path fetches and honours downstream stall.

Parameters:
PC_W, 8, program-counter and instruction-address width
INSN_W, 16, instruction segment width
RESET_PC, 8'h00, PC value loaded at reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  PC_W  instruction-memory word address
imem_req  out  1  fetch request; held high until imem_ack
imem_rdata  in  INSN_W  fetched instruction, valid when imem_ack=1
imem_ack  in  1  one-cycle read completion, any latency >=0 cycles after req
l_pc  in  1  PC load from control stage (redirect)
pc_sel  in  2  redirect target select {S11,S10}: 01 operand, 11 register, 10 stack, 00 reserved (treated as operand)
od_in  in  PC_W  direct operand target
reg_in  in  PC_W  register-indirect target
stack_in  in  PC_W  return address popped from stack
stall  in  1  downstream hold request
segment  out  INSN_W  instruction to CCG1; 16'h0000 (NOP) when not valid
pc_out  out  PC_W  address of following instruction (NPC)
valid  out  1  segment carries a real instruction
flush  out  1  one-cycle pulse telling CCG1/CCG2 to squash wrong-path contents

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=START, buffer empty.
  - Outputs: segment=16'h0000, pc_out=RESET_PC, valid=0, flush=0, imem_req=0, imem_addr=RESET_PC.
- States: START, FETCH, KILL, BUF.
  - imem_req=1 in FETCH and KILL only.
  - imem_addr = pc in FETCH; imem_addr = latched request address in KILL.
  - imem_addr is stable while imem_req=1.
- START -> FETCH unconditionally on the first edge after reset release.
- FETCH, imem_ack=1, stall=0, l_pc=0:
  - segment<=imem_rdata, valid<=1, pc_out<=pc+1, pc<=pc+1; stay in FETCH.
  - Throughput is 1 instruction/cycle with zero-latency memory.
- FETCH, imem_ack=1, stall=1:
  - Capture rdata and pc+1 into a one-entry buffer, pc<=pc+1, go to BUF.
  - segment, pc_out and valid hold their values.
- FETCH, imem_ack=0: valid<=0, segment<=16'h0000 (bubble), unless stall=1, in which case outputs hold.
- BUF, stall=0: outputs<=buffer, valid<=1, go to FETCH. BUF, stall=1: hold.
- While stall=1, the registered outputs (segment, pc_out, valid) never change.
- Redirect (l_pc=1) has priority over stall and ack:
  - Target mux: 01 -> od_in, 11 -> reg_in, 10 -> stack_in, 00 -> od_in.
  - pc<=target, buffer cleared, valid<=0, segment<=16'h0000, flush<=1 for exactly one cycle.
  - From FETCH with ack=1: rdata is discarded; next state FETCH at target.
  - From FETCH with ack=0: go to KILL. Keep req high and the old address until ack, discard that data, then go to FETCH at target.
  - In KILL, a further l_pc overwrites the target and the state stays KILL.
  - From BUF or START: next state FETCH at target.
- l_pc and stall in the same cycle: the redirect executes; stall applies from the next cycle.
- PC arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00, and pc_out wraps the same way.
- No imem_ack is ever accepted outside FETCH or KILL; a spurious ack is ignored.
- rst_n asserted mid-transaction: immediate return to reset values. An outstanding memory request is abandoned; the memory model must tolerate req dropping.

Test Plan:
- Reset, then zero-latency ack with mem[i]=16'h1000+i: segments 16'h1000, 16'h1001, 16'h1002 on consecutive cycles; pc_out 01, 02, 03; valid=1 continuously.
- 2-cycle ack latency: valid pattern 0,0,1 repeating; imem_addr stable while req=1; segment=16'h0000 on bubbles.
- stall=1 for 3 cycles as an ack arrives: outputs hold; buffer captures the next word; on stall release it is emitted exactly once; no instruction is lost or duplicated.
- l_pc=1, pc_sel=11, reg_in=8'h40 while a fetch from 8'h05 is outstanding (ack 2 cycles later): flush pulses 1 cycle; 8'h05 data is never emitted; next request address is 8'h40.
- l_pc with pc_sel=10, stack_in=8'h7A together with stall=1 and buffer full: buffer dropped; first valid segment is mem[8'h7A] with pc_out=8'h7B.
- pc=8'hFF fetch: pc_out=8'h00 and next imem_addr=8'h00; rst_n pulse mid-KILL: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipe_fetch_unit.sv
// -----------------------------------------------------------------------------
// pipe_fetch_unit
//
// Instruction-fetch stage of the 3-stage pipeline, feeding the CCG1 latch.
// Owns the program counter and runs the instruction-memory req/ack handshake.
// It applies redirects from the control stage (jump / call / return), squashes
// wrong-path fetches and honours the downstream stall through a one-entry
// skid buffer.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_addr      : instruction word address (stable while imem_req=1)
//   imem_req       : fetch request, held until imem_ack
//   imem_rdata     : fetched instruction, qualified by imem_ack
//   imem_ack       : single-cycle read completion (may be combinational)
//   l_pc           : redirect strobe from the control stage
//   pc_sel         : redirect source {S11,S10}: 01 od_in, 11 reg_in,
//                    10 stack_in, 00 od_in
//   od_in          : direct operand target
//   reg_in         : register-indirect target
//   stack_in       : return address popped from the stack
//   stall          : downstream hold request
//   segment        : instruction to CCG1, 16'h0000 (NOP) when not valid
//   pc_out         : address of the following instruction (NPC)
//   valid          : segment carries a real instruction
//   flush          : one-cycle squash pulse for CCG1/CCG2
// -----------------------------------------------------------------------------
module pipe_fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSN_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              imem_ack,
    input  logic              l_pc,
    input  logic [1:0]        pc_sel,
    input  logic [PC_W-1:0]   od_in,
    input  logic [PC_W-1:0]   reg_in,
    input  logic [PC_W-1:0]   stack_in,
    input  logic              stall,
    output logic [INSN_W-1:0] segment,
    output logic [PC_W-1:0]   pc_out,
    output logic              valid,
    output logic              flush
);

    // START : first cycle after reset, no request yet
    // FETCH : request outstanding at r_pc
    // KILL  : wrong-path request still outstanding at r_kill_addr; its data
    //         is thrown away and fetching resumes at r_pc once it completes
    // BUF   : skid buffer holds a word captured while stalled
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2,
        ST_BUF   = 2'd3
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_kill_addr;
    logic [INSN_W-1:0]   r_buf_seg;
    logic [PC_W-1:0]     r_buf_npc;

    logic [INSN_W-1:0]   r_segment;
    logic [PC_W-1:0]     r_pc_out;
    logic                r_valid;
    logic                r_flush;

    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_pc_inc;

    // Natural PC_W-bit wrap gives the modulo-2^PC_W increment (FF -> 00).
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Redirect target select; the reserved code 00 falls back to the operand.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_target = od_in;
        case (pc_sel)
            2'b11:   w_target = reg_in;
            2'b10:   w_target = stack_in;
            default: w_target = od_in;
        endcase
    end

    // The request is a pure decode of the registered state, so it cannot
    // glitch and cannot form a loop with a zero-latency (combinational) ack.
    // In KILL the address of the abandoned request is replayed so the memory
    // sees a stable address until it acknowledges.
    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_KILL);
    assign imem_addr = (r_state == ST_KILL) ? r_kill_addr : r_pc;

    assign segment = r_segment;
    assign pc_out  = r_pc_out;
    assign valid   = r_valid;
    assign flush   = r_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid buffer is only two registers, so it is reset along
            // with everything else; nothing here is large enough to be a RAM.
            r_state     <= ST_START;
            r_pc        <= RESET_PC;
            r_kill_addr <= RESET_PC;
            r_buf_seg   <= '0;
            r_buf_npc   <= RESET_PC;
            r_segment   <= '0;
            r_pc_out    <= RESET_PC;
            r_valid     <= 1'b0;
            r_flush     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the pre-edge value regardless of statement order.
            r_flush <= 1'b0;

            if (l_pc) begin
                // Redirect wins over stall and ack. The pipe is emptied and
                // squashed; a stall raised in the same cycle only takes
                // effect from the next cycle on.
                r_pc      <= w_target;
                r_valid   <= 1'b0;
                r_segment <= '0;
                r_flush   <= 1'b1;
                r_buf_seg <= '0;
                r_buf_npc <= RESET_PC;

                case (r_state)
                    ST_FETCH: begin
                        if (imem_ack) begin
                            // Wrong-path data arrives this cycle: just drop it.
                            r_state <= ST_FETCH;
                        end else begin
                            // Request still in flight: keep it alive at its
                            // original address until the memory completes.
                            r_state     <= ST_KILL;
                            r_kill_addr <= r_pc;
                        end
                    end
                    ST_KILL: begin
                        // A new target simply replaces the pending one. If the
                        // abandoned request completes in this same cycle there
                        // is nothing left to wait for.
                        r_state <= imem_ack ? ST_FETCH : ST_KILL;
                    end
                    default: begin
                        // START and BUF have no request outstanding.
                        r_state <= ST_FETCH;
                    end
                endcase
            end else begin
                case (r_state)
                    ST_START: begin
                        r_state <= ST_FETCH;
                    end

                    ST_FETCH: begin
                        if (imem_ack) begin
                            r_pc <= w_pc_inc;
                            if (stall) begin
                                // Downstream is full: park the word and its
                                // NPC so nothing is lost while outputs hold.
                                r_buf_seg <= imem_rdata;
                                r_buf_npc <= w_pc_inc;
                                r_state   <= ST_BUF;
                            end else begin
                                r_segment <= imem_rdata;
                                r_pc_out  <= w_pc_inc;
                                r_valid   <= 1'b1;
                            end
                        end else if (!stall) begin
                            // Memory still busy: insert a NOP bubble. Under
                            // stall the previous instruction must stay put.
                            r_valid   <= 1'b0;
                            r_segment <= '0;
                        end
                    end

                    ST_KILL: begin
                        // Completion of the squashed request; its data is
                        // never looked at.
                        if (imem_ack) begin
                            r_state <= ST_FETCH;
                        end
                    end

                    ST_BUF: begin
                        if (!stall) begin
                            r_segment <= r_buf_seg;
                            r_pc_out  <= r_buf_npc;
                            r_valid   <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end

                    default: begin
                        r_state <= ST_START;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_unit
//
// Directed bench for pipe_fetch_unit. A behavioural instruction memory holds
// mem[i] = 16'h1000 + i and acknowledges a request after a programmable number
// of waiting cycles (0 = same-cycle ack); it can also inject a spurious ack.
// A table of per-cycle vectors covers streaming, latency bubbles and stall;
// hand-written sequences cover redirects, KILL, PC wrap and async reset.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        l_pc;
    logic [1:0]  pc_sel;
    logic [7:0]  od_in;
    logic [7:0]  reg_in;
    logic [7:0]  stack_in;
    logic        stall;
    logic [15:0] segment;
    logic [7:0]  pc_out;
    logic        valid;
    logic        flush;

    int n_run  = 0;
    int n_fail = 0;

    pipe_fetch_unit #(
        .PC_W     (8),
        .INSN_W   (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .l_pc       (l_pc),
        .pc_sel     (pc_sel),
        .od_in      (od_in),
        .reg_in     (reg_in),
        .stack_in   (stack_in),
        .stall      (stall),
        .segment    (segment),
        .pc_out     (pc_out),
        .valid      (valid),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    logic [15:0] mem [256];
    int          lat;
    int          cnt;
    logic        spur;

    assign imem_ack   = (imem_req && (cnt == lat)) || spur;
    assign imem_rdata = mem[imem_addr];

    // Counts cycles the current request has been waiting; a dropped request
    // (reset, state change) simply restarts the count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= 0;
        else if (!imem_req || imem_ack) cnt <= 0;
        else                         cnt <= cnt + 1;
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        stall;
        logic        l_pc;
        logic [1:0]  sel;
        logic [3:0]  lat;
        logic        spur;
        logic        v;
        logic [15:0] seg;
        logic [7:0]  npc;
        logic        fl;
        logic        req;
        logic [7:0]  addr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic st, logic [3:0] lt, logic sp, logic v,
                                logic [15:0] seg, logic [7:0] npc, logic req,
                                logic [7:0] addr);
        vec_t r;
        r.stall = st;  r.l_pc = 1'b0; r.sel = 2'b00; r.lat = lt; r.spur = sp;
        r.v = v; r.seg = seg; r.npc = npc; r.fl = 1'b0; r.req = req; r.addr = addr;
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [15:0] seg,
                              input logic [7:0] npc, input logic fl, input logic req,
                              input logic [7:0] addr);
        check({tag, ".valid"},   32'(valid),   32'(v));
        check({tag, ".segment"}, 32'(segment), 32'(seg));
        check({tag, ".pc_out"},  32'(pc_out),  32'(npc));
        check({tag, ".flush"},   32'(flush),   32'(fl));
        check({tag, ".req"},     32'(imem_req), 32'(req));
        if (req) check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    endtask

    // Bubble/squash state where pc_out is not of interest.
    task automatic check_bub(input string tag, input logic fl, input logic req,
                             input logic [7:0] addr);
        check({tag, ".valid"},   32'(valid),   32'(0));
        check({tag, ".segment"}, 32'(segment), 32'(0));
        check({tag, ".flush"},   32'(flush),   32'(fl));
        check({tag, ".req"},     32'(imem_req), 32'(req));
        if (req) check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    endtask

    task automatic drive(input logic st, input logic lp, input logic [1:0] sel);
        stall  = st;
        l_pc   = lp;
        pc_sel = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a step: reset pulse released well before the next edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00);
        spur  = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst_n = 1'b0;
        lat = 0; spur = 1'b0;
        od_in = 8'h00; reg_in = 8'h40; stack_in = 8'h7A;
        drive(1'b0, 1'b0, 2'b00);

        // Zero latency streaming, then a 3-cycle stall around an ack
        // (spurious acks while parked in BUF must be ignored).
        vecs[0]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 8'h00); // START -> FETCH
        vecs[1]  = mk(0, 0, 0, 1, 16'h1000, 8'h01, 1, 8'h01);
        vecs[2]  = mk(0, 0, 0, 1, 16'h1001, 8'h02, 1, 8'h02);
        vecs[3]  = mk(0, 0, 0, 1, 16'h1002, 8'h03, 1, 8'h03);
        vecs[4]  = mk(1, 0, 0, 1, 16'h1002, 8'h03, 0, 8'h00); // 1003 buffered
        vecs[5]  = mk(1, 0, 1, 1, 16'h1002, 8'h03, 0, 8'h00);
        vecs[6]  = mk(1, 0, 1, 1, 16'h1002, 8'h03, 0, 8'h00);
        vecs[7]  = mk(0, 0, 0, 1, 16'h1003, 8'h04, 1, 8'h04); // buffer emitted
        vecs[8]  = mk(0, 0, 0, 1, 16'h1004, 8'h05, 1, 8'h05);
        // Two-cycle latency: valid 0,0,1 with a stable address
        vecs[9]  = mk(0, 2, 0, 0, 16'h0000, 8'h05, 1, 8'h05);
        vecs[10] = mk(0, 2, 0, 0, 16'h0000, 8'h05, 1, 8'h05);
        vecs[11] = mk(0, 2, 0, 1, 16'h1005, 8'h06, 1, 8'h06);
        vecs[12] = mk(0, 2, 0, 0, 16'h0000, 8'h06, 1, 8'h06);
        vecs[13] = mk(0, 2, 0, 0, 16'h0000, 8'h06, 1, 8'h06);
        vecs[14] = mk(0, 2, 0, 1, 16'h1006, 8'h07, 1, 8'h07);
        // Stall across the wait: outputs hold, ack lands in the buffer
        vecs[15] = mk(1, 2, 0, 1, 16'h1006, 8'h07, 1, 8'h07);
        vecs[16] = mk(1, 2, 0, 1, 16'h1006, 8'h07, 1, 8'h07);
        vecs[17] = mk(1, 2, 0, 1, 16'h1006, 8'h07, 0, 8'h00);
        vecs[18] = mk(0, 2, 0, 1, 16'h1007, 8'h08, 1, 8'h08);
        vecs[19] = mk(0, 2, 0, 0, 16'h0000, 8'h08, 1, 8'h08);

        // ---------------- reset values ----------------
        #12;
        check_outs("reset", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        check("reset.addr", 32'(imem_addr), 32'(8'h00));
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].l_pc, vecs[i].sel);
            lat  = int'(vecs[i].lat);
            spur = vecs[i].spur;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].seg, vecs[i].npc,
                       vecs[i].fl, vecs[i].req, vecs[i].addr);
        end
        spur = 1'b0;

        // ---------------- redirect while a fetch from 05 is outstanding ----------------
        do_reset();
        lat = 3; od_in = 8'h05;
        drive(0, 1, 2'b01); step(); check_bub("r_start", 1, 1, 8'h05);
        drive(0, 0, 2'b00); step(); check_bub("r_wait", 0, 1, 8'h05);
        drive(0, 1, 2'b11); step(); check_bub("r_kill", 1, 1, 8'h05);
        drive(0, 0, 2'b00); step(); check_bub("r_kill2", 0, 1, 8'h05);
        step();                     check_bub("r_tgt", 0, 1, 8'h40);
        for (int k = 0; k < 3; k++) begin
            step(); check_bub($sformatf("r_bub%0d", k), 0, 1, 8'h40);
        end
        step(); check_outs("r_first", 1, 16'h1040, 8'h41, 0, 1, 8'h41);

        // ---------------- return redirect with stall and full buffer ----------------
        do_reset();
        lat = 0; spur = 1'b1;                    // spurious ack in START
        drive(0, 0, 2'b00); step(); check_bub("s_start", 0, 1, 8'h00);
        spur = 1'b0;
        step(); check_outs("s_f0", 1, 16'h1000, 8'h01, 0, 1, 8'h01);
        drive(1, 0, 2'b00); step(); check_outs("s_buf", 1, 16'h1000, 8'h01, 0, 0, 8'h00);
        drive(1, 1, 2'b10); step(); check_bub("s_ret", 1, 1, 8'h7A);
        drive(1, 0, 2'b00); step(); check_bub("s_stall", 0, 0, 8'h00);
        drive(0, 0, 2'b00); step(); check_outs("s_first", 1, 16'h107A, 8'h7B, 0, 1, 8'h7B);

        // ---------------- PC wrap at 8'hFF (redirect discards an acked word) ----------------
        od_in = 8'hFF;
        drive(0, 1, 2'b01); step(); check_bub("w_jmp", 1, 1, 8'hFF);
        drive(0, 0, 2'b00); step(); check_outs("w_ff", 1, 16'h10FF, 8'h00, 0, 1, 8'h00);
        step();                     check_outs("w_00", 1, 16'h1000, 8'h01, 0, 1, 8'h01);

        // ---------------- async reset in the middle of KILL ----------------
        lat = 3; od_in = 8'h50;
        drive(0, 1, 2'b01); step(); check_bub("k_kill", 1, 1, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_outs("k_rst", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        check("k_rst.addr", 32'(imem_addr), 32'(8'h00));
        drive(0, 0, 2'b00);
        #2 rst_n = 1'b1;

        // ---------------- KILL retarget, reserved select ----------------
        lat = 2;
        step();                     check_bub("o_start", 0, 1, 8'h00);
        od_in = 8'h50;
        drive(0, 1, 2'b01); step(); check_bub("o_kill", 1, 1, 8'h00);
        od_in = 8'h60;
        drive(0, 1, 2'b00); step(); check_bub("o_kill2", 1, 1, 8'h00);
        drive(0, 0, 2'b00); step(); check_bub("o_tgt", 0, 1, 8'h60);
        step();                     check_bub("o_bub0", 0, 1, 8'h60);
        step();                     check_bub("o_bub1", 0, 1, 8'h60);
        step(); check_outs("o_first", 1, 16'h1060, 8'h61, 0, 1, 8'h61);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
